// File: rtl/axicb_pkg.sv
// Shared types and helpers for the AXI crossbar write-path arbitration.
// No logic of its own; consumed by the arbiter and its round-robin core.
// No flow control here; callers own all handshaking.
package axicb_pkg;

    // Largest master count the crossbar slave port supports
    localparam int MST_NB_MAX = 8;

    // Write-lock FSM encoding
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_t;

    // Only 4- and 8-master slave ports exist in the crossbar
    function automatic bit mst_nb_legal(input int n);
        return (n == 4) || (n == 8);
    endfunction

    // Index of the set bit in a one-hot vector; all-zero input yields 0
    function automatic logic [2:0] onehot2idx(input logic [MST_NB_MAX-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MST_NB_MAX; i++) begin
            if (oh[i]) idx |= 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/axicb_round_robin_core.sv
// Round-robin picker: one-hot grant among req, rotating priority past the last winner.
// Grant is combinational from req and the mask; the mask updates one cycle after en.
// No backpressure: the caller decides when a grant is taken by pulsing en.
module axicb_round_robin_core #(
    parameter int REQ_NB = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    input  logic              en,
    input  logic [REQ_NB-1:0] req,
    output logic [REQ_NB-1:0] grant
);

    localparam logic [REQ_NB-1:0] ONE = 1;

    logic [REQ_NB-1:0] mask;
    logic [REQ_NB-1:0] masked;
    logic [REQ_NB-1:0] pick_src;
    logic [REQ_NB-1:0] nxt_mask;

    // Prefer requesters above the last winner; wrap to the lowest requester otherwise
    always_comb begin
        masked   = req & mask;
        pick_src = (|masked) ? masked : req;
        grant    = pick_src & (~pick_src + ONE);
        // Keep only masters strictly above the winner; the top winner reopens everyone
        nxt_mask = grant[REQ_NB-1] ? '1 : ~((grant << 1) - ONE);
    end

    // Advance the priority mask whenever a grant is actually taken
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mask <= '1;
        end else if (srst) begin
            mask <= '1;
        end else if (en && (|req)) begin
            mask <= nxt_mask;
        end
    end

endmodule

// File: rtl/axicb_wr_arbiter.sv
// Write-path arbiter: locks one master onto the slave AW/W channels for a full write.
// Grant registered one cycle after req_awvalid; back-to-back grants with no bubble.
// Holds the lock until both AW and the wlast beat have handshaken; others wait on valid.
module axicb_wr_arbiter
    import axicb_pkg::*;
#(
    parameter int MST_NB = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    input  logic [MST_NB-1:0] req_awvalid,
    input  logic [MST_NB-1:0] req_wvalid,
    input  logic [MST_NB-1:0] req_wlast,
    input  logic              slv_awready,
    input  logic              slv_wready,
    output logic [MST_NB-1:0] grant,
    output logic              busy,
    output logic              aw_open,
    output logic              w_open
);

    localparam int IDX_W = $clog2(MST_NB);

    if (!mst_nb_legal(MST_NB)) begin : g_bad_mst_nb
        $error("axicb_wr_arbiter: MST_NB must be 4 or 8");
    end

    arb_state_t              state;
    logic                    aw_done;
    logic                    w_done;
    logic [MST_NB-1:0]       core_grant;
    logic [MST_NB_MAX-1:0]   grant_ext;
    logic [IDX_W-1:0]        g_idx;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    complete;
    logic                    others;
    logic                    load;

    axicb_round_robin_core #(
        .REQ_NB (MST_NB)
    ) u_rr (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .en      (load),
        .req     (req_awvalid),
        .grant   (core_grant)
    );

    // Select the owner's channel signals and detect handshakes and completion
    always_comb begin
        grant_ext             = '0;
        grant_ext[MST_NB-1:0] = grant;
        g_idx    = IDX_W'(onehot2idx(grant_ext));
        aw_open  = busy & ~aw_done;
        w_open   = busy & ~w_done;
        aw_hs    = aw_open & req_awvalid[g_idx] & slv_awready;
        w_hs     = w_open & req_wvalid[g_idx] & req_wlast[g_idx] & slv_wready;
        complete = busy & (aw_done | aw_hs) & (w_done | w_hs);
        // The owner's awvalid in its own AW handshake cycle is being consumed, not a new request
        others   = |(req_awvalid & ~(aw_hs ? grant : '0));
        load     = (state == IDLE) ? (|req_awvalid) : (complete & others);
    end

    // Lock FSM: grant on request, hold until both halves of the write are done
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            grant   <= '0;
            busy    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (srst) begin
            state   <= IDLE;
            grant   <= '0;
            busy    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_awvalid) begin
                        state   <= ACTIVE;
                        grant   <= core_grant;
                        busy    <= 1'b1;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (complete) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (others) begin
                            grant <= core_grant;
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                            busy  <= 1'b0;
                        end
                    end else begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
